alu_seq_unit: RTL and testbench
===============================

Name: alu_seq_unit

Overview:
- Handshaked, multi-cycle responder for the 32-bit ALU command set: ADD, SUB, AND, OR, SLL, SRA.
- Accepts one operation on a valid/ready request port and returns the registered result plus the isNotEqual, isLessThan and overflow flags on a valid/ready response port.
- Shifts are iterative: one bit per cycle.
- Sits between a command issuer (sequencer or bench) and the register writeback path.

Parameters:
WIDTH, 32, operand/result width
SHAMT_W, 5, shift-amount width; WIDTH must equal 2**SHAMT_W

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
in_opcode  input  5  00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLL, 00101 SRA
in_shamt  input  SHAMT_W  shift amount (SLL/SRA only)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
out_valid  output  1  response valid
out_ready  input  1  consumer accepts response
out_result  output  WIDTH  result
out_isNotEqual  output  1  A != B
out_isLessThan  output  1  signed A < B
out_overflow  output  1  signed overflow of ADD/SUB
out_illegal  output  1  opcode not in the supported set

Behaviour:

Clock and reset:
- One clock; reset is asynchronous and active-low (reset_n).
- While reset_n=0: state=IDLE, in_ready=0, out_valid=0, and all out_* data and flags = 0.
- After release: in_ready=1 from the first rising edge.
- Reset mid-operation aborts the operation; no response is produced.

States:
- IDLE: in_ready=1. On in_valid&in_ready at an edge, capture opcode, shamt, A and B, load count=shamt, and go to EXEC.
- EXEC: in_ready=0, out_valid=0.
  - ADD/SUB/AND/OR/illegal: compute in one cycle and go to DONE.
  - SLL/SRA: if count=0, go to DONE with result=A. Otherwise shift the working register one bit per cycle (SLL fills 0; SRA replicates the MSB) and decrement count; go to DONE on the cycle count reaches 0.
- DONE: out_valid=1; outputs are stable and held until out_ready=1 at an edge, then go to IDLE.
  - Same-cycle new acceptance is not allowed; in_ready stays 0 in DONE.

Latency and throughput:
- Latency from the accept edge to out_valid high: 2 cycles for non-shift ops; 2+shamt cycles for shifts.
- Minimum issue interval with out_ready tied to 1: 3 cycles for non-shift ops.

Arithmetic:
- All arithmetic is modulo 2**WIDTH.
- SUB = A + ~B + 1.
- Overflow, ADD: A[msb]==B[msb] and result[msb]!=A[msb].
- Overflow, SUB: A[msb]!=B[msb] and diff[msb]!=A[msb].
- out_overflow=0 for non-ADD/SUB opcodes.

Flags:
- out_isNotEqual and out_isLessThan are computed from A-B for every opcode.
- isLessThan = diff[msb] XOR sub_overflow, so it stays correct across overflow.

Illegal opcodes:
- out_result=0, out_overflow=0, out_illegal=1; flags are still computed.
- Same latency as ADD.

Other rules:
- Inputs are sampled only at the accept edge; later changes to in_* are ignored.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Reset, then ADD A=0x40000000, B=0x40000000, out_ready=1 -> out_valid 2 cycles after accept; result=0x80000000, overflow=1, isNotEqual=0, isLessThan=0.
- SUB A=0x80000000, B=0x0F000000 -> result=0x71000000, overflow=1. Then SUB A=0x80000001, B=0x7FFFFFFF -> isLessThan=1, isNotEqual=1, overflow=1.
- SLL A=0x00000001 for shamt 0, 1, 16, 31 -> results 0x1, 0x2, 0x00010000, 0x80000000; out_valid at 2, 3, 18 and 33 cycles after accept respectively. SRA A=0x80000000, shamt=4 -> 0xF8000000.
- Backpressure: AND A=0xFFFFFFFF, B=0x0000FFFF with out_ready=0 for 5 cycles -> out_valid held; result 0x0000FFFF stable; in_ready=0 throughout; in_valid pulses are ignored; IDLE follows the out_ready edge.
- Opcode 0b11111, A=5, B=5 -> result=0, out_illegal=1, overflow=0, isNotEqual=0.
- reset_n asserted for 1 cycle during SLL shamt=20 at count=10 -> out_valid and outputs 0 immediately; in_ready=1 after release; no stale response. A following OR A=0xF0, B=0x0F returns 0xFF.

Source files
------------

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle between a command issuer and the sequential ALU.
// The issuer drives the master side; alu_seq_unit sits on the slave side.
interface alu_seq_unit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) ();
  localparam int unsigned OPC_W = 5;

  logic               in_valid;
  logic               in_ready;
  logic [OPC_W-1:0]   in_opcode;
  logic [SHAMT_W-1:0] in_shamt;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;

  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic               out_isNotEqual;
  logic               out_isLessThan;
  logic               out_overflow;
  logic               out_illegal;

  modport master (
    output in_valid, in_opcode, in_shamt, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_isNotEqual,
           out_isLessThan, out_overflow, out_illegal
  );

  modport slave (
    input  in_valid, in_opcode, in_shamt, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_isNotEqual,
           out_isLessThan, out_overflow, out_illegal
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked multi-cycle ALU: single-cycle ADD/SUB/AND/OR, bit-serial SLL/SRA.
// IDLE accepts, EXEC computes (one shift per cycle), DONE holds the response.
module alu_seq_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic           clock,
  input  logic           reset_n,
  alu_seq_unit_if.slave  bus
);
  localparam int unsigned OPC_W = 5;
  localparam int unsigned MSB   = WIDTH - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [OPC_W-1:0] OP_ADD = 5'b00000;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00001;
  localparam logic [OPC_W-1:0] OP_AND = 5'b00010;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SLL = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SRA = 5'b00101;

  logic [1:0]         state_q,      state_d;
  logic [OPC_W-1:0]   opc_q,        opc_d;
  logic [WIDTH-1:0]   a_q,          a_d;
  logic [WIDTH-1:0]   b_q,          b_d;
  logic [SHAMT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0]   work_q,       work_d;
  logic               in_ready_q,   in_ready_d;
  logic               out_valid_q,  out_valid_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic               ne_q,         ne_d;
  logic               lt_q,         lt_d;
  logic               ovf_q,        ovf_d;
  logic               ill_q,        ill_d;

  logic [WIDTH-1:0]   sum_c;
  logic [WIDTH-1:0]   diff_c;
  logic               add_ovf_c;
  logic               sub_ovf_c;
  logic               lt_c;
  logic               ne_c;
  logic               is_shift_c;
  logic [WIDTH-1:0]   res_c;
  logic               ovf_c;
  logic               ill_c;

  // Shared adder/subtractor; the compare flags always come from A-B.
  always_comb begin
    sum_c      = a_q + b_q;
    diff_c     = a_q + ~b_q + WIDTH'(1);
    add_ovf_c  = (a_q[MSB] == b_q[MSB]) && (sum_c[MSB]  != a_q[MSB]);
    sub_ovf_c  = (a_q[MSB] != b_q[MSB]) && (diff_c[MSB] != a_q[MSB]);
    lt_c       = diff_c[MSB] ^ sub_ovf_c;
    ne_c       = (a_q != b_q);
    is_shift_c = (opc_q == OP_SLL) || (opc_q == OP_SRA);
  end

  // Result select; shifts deliver the working register once the count drains.
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    ill_c = 1'b0;
    case (opc_q)
      OP_ADD: begin
        res_c = sum_c;
        ovf_c = add_ovf_c;
      end
      OP_SUB: begin
        res_c = diff_c;
        ovf_c = sub_ovf_c;
      end
      OP_AND:  res_c = a_q & b_q;
      OP_OR:   res_c = a_q | b_q;
      OP_SLL:  res_c = work_q;
      OP_SRA:  res_c = work_q;
      default: ill_c = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    work_d       = work_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    ne_d         = ne_q;
    lt_d         = lt_q;
    ovf_d        = ovf_q;
    ill_d        = ill_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          opc_d   = bus.in_opcode;
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          cnt_d   = bus.in_shamt;
          work_d  = bus.in_a;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_shift_c && (cnt_q != '0)) begin
          work_d = (opc_q == OP_SLL) ? {work_q[MSB-1:0], 1'b0}
                                     : {work_q[MSB], work_q[MSB:1]};
          cnt_d  = cnt_q - SHAMT_W'(1);
        end else begin
          state_d      = ST_DONE;
          out_valid_d  = 1'b1;
          out_result_d = res_c;
          ne_d         = ne_c;
          lt_d         = lt_c;
          ovf_d        = ovf_c;
          ill_d        = ill_c;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // No acceptance in the cycle a response is consumed: ready only follows IDLE.
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      opc_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      work_q       <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      ne_q         <= 1'b0;
      lt_q         <= 1'b0;
      ovf_q        <= 1'b0;
      ill_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      work_q       <= work_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      ne_q         <= ne_d;
      lt_q         <= lt_d;
      ovf_q        <= ovf_d;
      ill_q        <= ill_d;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_result     = out_result_q;
  assign bus.out_isNotEqual = ne_q;
  assign bus.out_isLessThan = lt_q;
  assign bus.out_overflow   = ovf_q;
  assign bus.out_illegal    = ill_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: vector table through a scoreboard queue, plus
// hand-written sequences for issue interval, backpressure and mid-op reset.
module tb_alu_seq_unit;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned NVEC    = 17;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_seq_unit_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  alu_seq_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [4:0]  opc;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ne;
    logic        lt;
    logic        ovf;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ne;
    logic        lt;
    logic        ovf;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.res = v.res;
    e.ne  = v.ne;
    e.lt  = v.lt;
    e.ovf = v.ovf;
    e.ill = v.ill;
    e.lat = (v.opc == 5'd4 || v.opc == 5'd5) ? 2 + int'(v.shamt) : 2;
    return e;
  endfunction

  // Drive one request, wait (bounded) for acceptance, then scramble inputs.
  task automatic issue(input vec_t v, output int acc_cyc);
    int n = 0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = v.opc;
    bus.in_shamt  = v.shamt;
    bus.in_a      = v.a;
    bus.in_b      = v.b;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    @(posedge clock);
    #1;
    acc_cyc       = cyc;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 5'($urandom);
    bus.in_shamt  = 5'($urandom);
    bus.in_a      = $urandom;
    bus.in_b      = $urandom;
    exp_q.push_back(mk_exp(v));
  endtask

  // Called #1 after the accept edge; latency counts the accept cycle as 1.
  task automatic wait_resp(input string tag);
    int   lat = 1;
    exp_t e;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) begin
      check({tag, "_resp_timeout"}, 32'd0, 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_resp"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_latency"},    32'(lat),             32'(e.lat));
    check({tag, "_result"},     bus.out_result,       e.res);
    check({tag, "_isNotEqual"}, 32'(bus.out_isNotEqual), 32'(e.ne));
    check({tag, "_isLessThan"}, 32'(bus.out_isLessThan), 32'(e.lt));
    check({tag, "_overflow"},   32'(bus.out_overflow),   32'(e.ovf));
    check({tag, "_illegal"},    32'(bus.out_illegal),    32'(e.ill));
  endtask

  task automatic release_resp(input string tag);
    bus.out_ready = 1'b1;
    tick();
    check({tag, "_valid_after_pop"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_ready_after_pop"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   a0;
    int   a1;
    int   seen;
    vec_t v;

    vecs[0]  = '{5'd0,  5'd0,  32'h40000000, 32'h40000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{5'd1,  5'd0,  32'h80000000, 32'h0F000000, 32'h71000000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{5'd1,  5'd0,  32'h80000001, 32'h7FFFFFFF, 32'h00000002, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{5'd4,  5'd0,  32'h00000001, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'd4,  5'd1,  32'h00000001, 32'h00000000, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'd4,  5'd16, 32'h00000001, 32'h00000000, 32'h00010000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{5'd4,  5'd31, 32'h00000001, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{5'd5,  5'd4,  32'h80000000, 32'h00000000, 32'hF8000000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{5'd2,  5'd0,  32'hFFFFFFFF, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{5'd3,  5'd0,  32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{5'd31, 5'd0,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{5'd0,  5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{5'd1,  5'd0,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{5'd6,  5'd3,  32'h00000003, 32'h00000009, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{5'd5,  5'd2,  32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{5'd0,  5'd7,  32'h00000001, 32'h00000002, 32'h00000003, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{5'd5,  5'd31, 32'h40000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_shamt  = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready",   32'(bus.in_ready),       32'd0);
    check("rst_out_valid",  32'(bus.out_valid),      32'd0);
    check("rst_result",     bus.out_result,          32'd0);
    check("rst_flags",      32'({bus.out_isNotEqual, bus.out_isLessThan,
                                 bus.out_overflow, bus.out_illegal}), 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Vector table
    bus.out_ready = 1'b1;
    for (int i = 0; i < int'(NVEC); i++) begin
      issue(vecs[i], a0);
      wait_resp($sformatf("vec%0d", i));
      release_resp($sformatf("vec%0d", i));
    end

    // Back-to-back issue interval with out_ready held high
    issue(vecs[15], a0);
    wait_resp("b2b_first");
    release_resp("b2b_first");
    issue(vecs[11], a1);
    check("issue_interval", 32'(a1 - a0), 32'd3);
    wait_resp("b2b_second");
    release_resp("b2b_second");

    // Backpressure: response held, in_valid pulses ignored
    bus.out_ready = 1'b0;
    issue(vecs[8], a0);
    wait_resp("bp");
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = 1'(i % 2 == 0);
      bus.in_opcode = 5'd0;
      bus.in_a      = $urandom;
      bus.in_b      = $urandom;
      tick();
      check($sformatf("bp_hold%0d_valid", i),  32'(bus.out_valid), 32'd1);
      check($sformatf("bp_hold%0d_result", i), bus.out_result,     32'h0000FFFF);
      check($sformatf("bp_hold%0d_ready", i),  32'(bus.in_ready),  32'd0);
    end
    bus.in_valid = 1'b0;
    release_resp("bp");
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("bp_no_extra_resp", 32'(seen), 32'd0);

    // Reset in the middle of SLL shamt=20, after 10 shift steps
    bus.out_ready = 1'b1;
    v = '{5'd4, 5'd20, 32'h00000001, 32'h00000000, 32'h00100000, 1'b1, 1'b0, 1'b0, 1'b0};
    issue(v, a0);
    repeat (10) tick();
    check("mid_valid_before_rst", 32'(bus.out_valid), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("mid_rst_result",    bus.out_result,     32'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();
    check("mid_rst_ready_after_release", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("mid_rst_no_stale_resp", 32'(seen), 32'd0);
    issue(vecs[9], a0);
    wait_resp("after_rst_or");
    release_resp("after_rst_or");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
